dmac_write_burst_gen: RTL and testbench
=======================================

DMAC_WRITE_BURST_GEN -- requirements
Module: dmac_write_burst_gen

Interface
REQ-001 SHALL have parameter ADDR_WD, default 32, address and length width.
REQ-002 SHALL have parameter DATA_WD, default 32, data bus width (STRB_WD = DATA_WD/8).
REQ-003 SHALL have parameter MAX_BURST_LEN, default 16, maximum beats per INCR burst (1..256).
REQ-004 SHALL have parameter CMD_DEPTH, default 4, command FIFO depth (power of 2, >=2).
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 8, maximum issued bursts awaiting response.
REQ-006 SHALL have parameter ID_WD, default 3, channel-ID width.
REQ-007 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high; the only clock is clk.
REQ-008 SHALL have cmd_in_valid/cmd_in_ready  in/out  1  command handshake; cmd_in_id  in  ID_WD; cmd_in_dst_addr  in  ADDR_WD; cmd_in_len  in  ADDR_WD  bytes; cmd_in_burst  in  2; cmd_in_size  in  3; cmd_in_src_offset  in  $clog2(STRB_WD).
REQ-009 SHALL have wr_req_valid/wr_req_ready  out/in  1; wr_req_addr  out  ADDR_WD; wr_req_len  out  8  beats-1; wr_req_burst  out  2; wr_req_size  out  3; wr_req_data_offset  out  $clog2(STRB_WD); wr_req_id  out  ID_WD; wr_req_last  out  1  final burst of command.
REQ-010 SHALL have wr_resp_valid  in  1; wr_resp_ready  out  1; wr_resp_resp  in  2  AXI BRESP.
REQ-011 SHALL have done_valid/done_ready  out/in  1; done_id  out  ID_WD; done_err  out  1  any non-OKAY response.

Function
REQ-012 SHALL buffer commands in a CMD_DEPTH FIFO; cmd_in_ready = !fifo_full; write on valid&&ready.
REQ-013 SHALL run FSM IDLE -> LOAD -> ISSUE -> DRAIN -> DONE -> IDLE, one command active at a time.
REQ-014 IDLE: on FIFO non-empty pop head and go LOAD; LOAD: register addr, remaining bytes, attributes, clear error flag, go ISSUE (or DRAIN if length 0).
REQ-015 With empty FIFO and IDLE FSM, command accepted in cycle N SHALL give first wr_req_valid in cycle N+3.
REQ-016 ISSUE: wr_req_valid=1 while outstanding < MAX_OUTSTANDING; all wr_req_* SHALL stay stable until wr_req_ready.
REQ-017 Burst beats = min(remaining>>size, MAX_BURST_LEN, 4 KB-boundary beats); FIXED burst: cap 16, no boundary term, address not advanced.
REQ-018 4 KB-boundary beats = (4096 - addr[11:0]) >> size; wr_req_len = beats-1 (8-bit).
REQ-019 On wr_req fire: addr += beats<<size (INCR), remaining -= beats<<size; next burst valid following cycle; wr_req_last=1 iff remaining becomes 0; then go DRAIN.
REQ-020 Outstanding counter: +1 on wr_req fire, -1 on wr_resp fire, unchanged on simultaneous; width $clog2(MAX_OUTSTANDING+1).
REQ-021 wr_resp_ready SHALL be 1 whenever outstanding > 0; a response with outstanding = 0 SHALL be ignored.
REQ-022 error flag SHALL set sticky on wr_resp fire with wr_resp_resp[1]=1.
REQ-023 DRAIN: go DONE when outstanding = 0; DONE: done_valid=1, done_id, done_err held until done_ready, then IDLE.
REQ-024 Zero-length command SHALL issue no bursts and produce done with done_err=0.
REQ-025 cmd_in_len and cmd_in_dst_addr are aligned to 2^size by contract; low bits SHALL be ignored.

Reset
REQ-026 On rst: FSM IDLE, FIFO empty, outstanding 0, error 0; wr_req_valid, done_valid, wr_resp_ready = 0; cmd_in_ready = 1 from first cycle after rst deasserts.
REQ-027 rst mid-command SHALL discard FIFO contents and outstanding state with no done emitted.

Configuration
REQ-028 Macro DMAC_WR_4K_BOUNDARY_EN defined: REQ-017/018 boundary term applied; undefined: term omitted, bursts limited only by remaining and MAX_BURST_LEN.

Structure
REQ-029 Burst-type constants, BURST/LEN/SIZE widths and the FSM state enum SHALL live in axi4_pkg / dmac_pkg.
REQ-030 Burst-length computation SHALL be a combinational sub-module dmac_burst_calc.

Verification
REQ-031 addr 0x1000, len 128 B, size 2, INCR, MAX_BURST_LEN 16 -> bursts 0x1000 len 15, 0x1040 len 15; last on second; done_err 0.
REQ-032 addr 0x0FF8, len 32 B, size 2, macro on -> 0x0FF8 len 1, 0x1000 len 5; macro off -> single 0x0FF8 len 7.
REQ-033 MAX_OUTSTANDING 2, 4 bursts, responses withheld -> wr_req_valid drops after 2 fires, resumes on first response.
REQ-034 Second response SLVERR (2'b10) -> done_err 1, done_id = cmd_in_id; next command done_err 0.
REQ-035 CMD_DEPTH+1 back-to-back commands with wr_req_ready 0 -> cmd_in_ready 0 after CMD_DEPTH+1 accepts (FIFO plus active).
REQ-036 len 0 -> no wr_req_valid, done_valid within 4 cycles; rst during ISSUE -> all outputs zero next cycle.

Source files
------------

// File: rtl/dmac_pkg.sv
// Shared constants for the DMA write burst generator: AXI burst encodings,
// AXI field widths and the controller state encoding.
package dmac_pkg;

    // AXI field widths
    localparam int BURST_WD = 2;
    localparam int LEN_WD   = 8;
    localparam int SIZE_WD  = 3;

    // AXI burst types
    localparam logic [BURST_WD-1:0] BURST_FIXED = 2'b00;
    localparam logic [BURST_WD-1:0] BURST_INCR  = 2'b01;

    // AXI limits
    localparam int FIXED_MAX_BEATS = 16;
    localparam int PAGE_BYTES      = 4096;

    // Controller states (one command in flight at a time)
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_ISSUE = 3'd2;
    localparam state_t ST_DRAIN = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/dmac_burst_calc.sv
// Combinational burst sizing: beats of the next burst given the current
// address, remaining bytes, burst type and beat size.
// Build option: DMAC_WR_4K_BOUNDARY_EN adds the 4 KB page-crossing limit
// to INCR bursts; without it bursts are limited only by the remaining
// length and MAX_BURST_LEN.
module dmac_burst_calc
    import dmac_pkg::*;
#(
    parameter int ADDR_WD       = 32,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [ADDR_WD-1:0]  addr,
    input  logic [ADDR_WD-1:0]  remaining,
    input  logic [BURST_WD-1:0] burst,
    input  logic [SIZE_WD-1:0]  size,
    output logic [8:0]          beats,
    output logic [ADDR_WD-1:0]  bytes
);

    localparam logic [ADDR_WD-1:0] CAP_INCR  = ADDR_WD'(MAX_BURST_LEN);
    localparam logic [ADDR_WD-1:0] CAP_FIXED = ADDR_WD'(FIXED_MAX_BEATS);

    logic [ADDR_WD-1:0] rem_beats;
    logic [ADDR_WD-1:0] cap_beats;
    logic [ADDR_WD-1:0] bnd_beats;
    logic [ADDR_WD-1:0] lim_beats;
    logic               unused_addr_bits;

`ifdef DMAC_WR_4K_BOUNDARY_EN
    logic [12:0] to_page_end;

    // Beats that still fit before the next 4 KB page boundary
    always_comb begin
        to_page_end = 13'(PAGE_BYTES) - {1'b0, addr[11:0]};
        bnd_beats   = ADDR_WD'(to_page_end >> size);
    end

    assign unused_addr_bits = ^addr[ADDR_WD-1:12];
`else
    assign bnd_beats        = '1;
    assign unused_addr_bits = ^addr;
`endif

    // Smallest of remaining beats, burst-type cap and page limit
    always_comb begin
        rem_beats = remaining >> size;
        cap_beats = (burst == BURST_FIXED) ? CAP_FIXED : CAP_INCR;
        lim_beats = (rem_beats < cap_beats) ? rem_beats : cap_beats;
        if ((burst != BURST_FIXED) && (bnd_beats < lim_beats)) begin
            lim_beats = bnd_beats;
        end
        beats = 9'(lim_beats);
        bytes = lim_beats << size;
    end

endmodule

// File: rtl/dmac_write_burst_gen.sv
// DMA write burst generator: queues write commands, splits each into AXI
// write bursts, tracks outstanding responses and reports completion with
// a sticky error flag.
// Build option: DMAC_WR_4K_BOUNDARY_EN (see dmac_burst_calc).
module dmac_write_burst_gen
    import dmac_pkg::*;
#(
    parameter int ADDR_WD         = 32,
    parameter int DATA_WD         = 32,
    parameter int MAX_BURST_LEN   = 16,
    parameter int CMD_DEPTH       = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int ID_WD           = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    // command input
    input  logic                         cmd_in_valid,
    output logic                         cmd_in_ready,
    input  logic [ID_WD-1:0]             cmd_in_id,
    input  logic [ADDR_WD-1:0]           cmd_in_dst_addr,
    input  logic [ADDR_WD-1:0]           cmd_in_len,
    input  logic [1:0]                   cmd_in_burst,
    input  logic [2:0]                   cmd_in_size,
    input  logic [$clog2(DATA_WD/8)-1:0] cmd_in_src_offset,
    // write burst requests
    output logic                         wr_req_valid,
    input  logic                         wr_req_ready,
    output logic [ADDR_WD-1:0]           wr_req_addr,
    output logic [7:0]                   wr_req_len,
    output logic [1:0]                   wr_req_burst,
    output logic [2:0]                   wr_req_size,
    output logic [$clog2(DATA_WD/8)-1:0] wr_req_data_offset,
    output logic [ID_WD-1:0]             wr_req_id,
    output logic                         wr_req_last,
    // write responses
    input  logic                         wr_resp_valid,
    output logic                         wr_resp_ready,
    input  logic [1:0]                   wr_resp_resp,
    // completion
    output logic                         done_valid,
    input  logic                         done_ready,
    output logic [ID_WD-1:0]             done_id,
    output logic                         done_err
);

    localparam int STRB_WD = DATA_WD / 8;
    localparam int OFF_WD  = $clog2(STRB_WD);
    localparam int PTR_WD  = $clog2(CMD_DEPTH);
    localparam int OUT_WD  = $clog2(MAX_OUTSTANDING + 1);
    localparam int CMD_WD  = ID_WD + 2 * ADDR_WD + BURST_WD + SIZE_WD + OFF_WD;
    localparam logic [OUT_WD-1:0] OUT_MAX = OUT_WD'(MAX_OUTSTANDING);

    // ---------------- command FIFO ----------------
    logic [CMD_WD-1:0] mem [CMD_DEPTH];
    logic [CMD_WD-1:0] rd_data_reg;
    logic [PTR_WD:0]   wr_ptr_reg;
    logic [PTR_WD:0]   rd_ptr_reg;
    logic [CMD_WD-1:0] cmd_in_word;
    logic              fifo_full;
    logic              fifo_empty;
    logic              cmd_push;
    logic              cmd_pop;

    // ---------------- active command ----------------
    state_t              state_reg;
    logic [ADDR_WD-1:0]  addr_reg;
    logic [ADDR_WD-1:0]  rem_reg;
    logic [BURST_WD-1:0] burst_reg;
    logic [SIZE_WD-1:0]  size_reg;
    logic [OFF_WD-1:0]   off_reg;
    logic [ID_WD-1:0]    id_reg;
    logic                err_reg;
    logic [OUT_WD-1:0]   out_reg;

    logic [ID_WD-1:0]    head_id;
    logic [ADDR_WD-1:0]  head_addr;
    logic [ADDR_WD-1:0]  head_len;
    logic [BURST_WD-1:0] head_burst;
    logic [SIZE_WD-1:0]  head_size;
    logic [OFF_WD-1:0]   head_off;
    logic [ADDR_WD-1:0]  size_mask;
    logic [ADDR_WD-1:0]  head_len_aligned;

    logic [8:0]          beats;
    logic [ADDR_WD-1:0]  bytes;
    logic                in_issue;
    logic                req_fire;
    logic                resp_fire;
    logic                burst_last;

    assign cmd_in_word = {cmd_in_id, cmd_in_dst_addr, cmd_in_len,
                          cmd_in_burst, cmd_in_size, cmd_in_src_offset};
    assign fifo_empty  = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full   = (wr_ptr_reg[PTR_WD] != rd_ptr_reg[PTR_WD]) &&
                         (wr_ptr_reg[PTR_WD-1:0] == rd_ptr_reg[PTR_WD-1:0]);
    assign cmd_in_ready = !fifo_full;
    assign cmd_push     = cmd_in_valid && cmd_in_ready;
    assign cmd_pop      = (state_reg == ST_IDLE) && !fifo_empty;

    // FIFO storage write (no reset so it maps onto RAM)
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            mem[wr_ptr_reg[PTR_WD-1:0]] <= cmd_in_word;
        end
    end

    // Registered FIFO read: head appears in rd_data_reg during LOAD
    always_ff @(posedge clk) begin
        if (cmd_pop) begin
            rd_data_reg <= mem[rd_ptr_reg[PTR_WD-1:0]];
        end
    end

    // FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (cmd_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (cmd_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    assign {head_id, head_addr, head_len, head_burst, head_size, head_off} = rd_data_reg;

    // Address and length are aligned to the beat size by dropping low bits
    assign size_mask        = ~((ADDR_WD'(1) << head_size) - ADDR_WD'(1));
    assign head_len_aligned = head_len & size_mask;

    dmac_burst_calc #(
        .ADDR_WD       (ADDR_WD),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_burst_calc (
        .addr      (addr_reg),
        .remaining (rem_reg),
        .burst     (burst_reg),
        .size      (size_reg),
        .beats     (beats),
        .bytes     (bytes)
    );

    assign in_issue   = (state_reg == ST_ISSUE);
    assign burst_last = (rem_reg == bytes);
    assign req_fire   = wr_req_valid && wr_req_ready;
    assign resp_fire  = wr_resp_valid && wr_resp_ready;

    // Command sequencing: load head, issue bursts, wait for responses, report
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            rem_reg   <= '0;
            burst_reg <= '0;
            size_reg  <= '0;
            off_reg   <= '0;
            id_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) state_reg <= ST_LOAD;
                end
                ST_LOAD: begin
                    addr_reg  <= head_addr & size_mask;
                    rem_reg   <= head_len_aligned;
                    burst_reg <= head_burst;
                    size_reg  <= head_size;
                    off_reg   <= head_off;
                    id_reg    <= head_id;
                    state_reg <= (head_len_aligned == '0) ? ST_DRAIN : ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (req_fire) begin
                        rem_reg <= rem_reg - bytes;
                        if (burst_reg != BURST_FIXED) addr_reg <= addr_reg + bytes;
                        if (burst_last) state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_reg == '0) state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    if (done_ready) state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Sticky error flag, cleared when a new command is loaded
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (state_reg == ST_LOAD) begin
            err_reg <= 1'b0;
        end else if (resp_fire && wr_resp_resp[1]) begin
            err_reg <= 1'b1;
        end
    end

    // Outstanding burst counter
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg <= '0;
        end else begin
            case ({req_fire, resp_fire})
                2'b10:   out_reg <= out_reg + 1'b1;
                2'b01:   out_reg <= out_reg - 1'b1;
                default: out_reg <= out_reg;
            endcase
        end
    end

    // Request fields are forced to zero outside ISSUE so idle outputs are clean
    assign wr_req_valid       = in_issue && (out_reg < OUT_MAX);
    assign wr_req_addr        = in_issue ? addr_reg : '0;
    assign wr_req_len         = in_issue ? LEN_WD'(beats - 9'd1) : '0;
    assign wr_req_burst       = in_issue ? burst_reg : '0;
    assign wr_req_size        = in_issue ? size_reg : '0;
    assign wr_req_data_offset = in_issue ? off_reg : '0;
    assign wr_req_id          = in_issue ? id_reg : '0;
    assign wr_req_last        = in_issue && burst_last;

    assign wr_resp_ready = (out_reg != '0);

    assign done_valid = (state_reg == ST_DONE);
    assign done_id    = done_valid ? id_reg : '0;
    assign done_err   = done_valid && err_reg;

endmodule

// File: tb/tb_dmac_write_burst_gen.sv
// Randomized self-checking bench for dmac_write_burst_gen with a
// transaction-level reference model (burst list per command, done list,
// outstanding count, per-command error accumulation).
module tb_dmac_write_burst_gen;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXB = 16;
    localparam int DEP  = 4;
    localparam int MAXO = 2;
    localparam int IDW  = 3;
    localparam int OW   = $clog2(DW / 8);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_in_valid = 1'b0;
    logic          cmd_in_ready;
    logic [IDW-1:0] cmd_in_id = '0;
    logic [AW-1:0] cmd_in_dst_addr = '0;
    logic [AW-1:0] cmd_in_len = '0;
    logic [1:0]    cmd_in_burst = '0;
    logic [2:0]    cmd_in_size = '0;
    logic [OW-1:0] cmd_in_src_offset = '0;
    logic          wr_req_valid;
    logic          wr_req_ready = 1'b0;
    logic [AW-1:0] wr_req_addr;
    logic [7:0]    wr_req_len;
    logic [1:0]    wr_req_burst;
    logic [2:0]    wr_req_size;
    logic [OW-1:0] wr_req_data_offset;
    logic [IDW-1:0] wr_req_id;
    logic          wr_req_last;
    logic          wr_resp_valid = 1'b0;
    logic          wr_resp_ready;
    logic [1:0]    wr_resp_resp = '0;
    logic          done_valid;
    logic          done_ready = 1'b0;
    logic [IDW-1:0] done_id;
    logic          done_err;

    always #5 clk = ~clk;

    dmac_write_burst_gen #(
        .ADDR_WD(AW), .DATA_WD(DW), .MAX_BURST_LEN(MAXB),
        .CMD_DEPTH(DEP), .MAX_OUTSTANDING(MAXO), .ID_WD(IDW)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_in_valid(cmd_in_valid), .cmd_in_ready(cmd_in_ready),
        .cmd_in_id(cmd_in_id), .cmd_in_dst_addr(cmd_in_dst_addr),
        .cmd_in_len(cmd_in_len), .cmd_in_burst(cmd_in_burst),
        .cmd_in_size(cmd_in_size), .cmd_in_src_offset(cmd_in_src_offset),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len),
        .wr_req_burst(wr_req_burst), .wr_req_size(wr_req_size),
        .wr_req_data_offset(wr_req_data_offset), .wr_req_id(wr_req_id),
        .wr_req_last(wr_req_last),
        .wr_resp_valid(wr_resp_valid), .wr_resp_ready(wr_resp_ready),
        .wr_resp_resp(wr_resp_resp),
        .done_valid(done_valid), .done_ready(done_ready),
        .done_id(done_id), .done_err(done_err)
    );

    typedef struct {
        longint unsigned addr;
        int              len;
        int              last;
        int              id;
        int              burst;
        int              size;
        int              off;
    } burst_t;

    burst_t exp_q[$];
    int     done_q[$];
    logic [1:0] script_q[$];
    int     model_out = 0;
    int     err_acc = 0;
    int     fires = 0;
    int     last_done_id = -1;
    int     last_done_err = -1;
    int     checks = 0;
    int     errors = 0;

    int     ready_mode = 1;   // 0: low, 1: high, 2: random
    int     done_mode = 1;
    int     resp_mode = 1;    // 0: off, 1: random, 2: manual pulses
    int     manual_pending = 0;
    int     rand_err_en = 0;

    task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: split a command into bursts with plain arithmetic
    task automatic model_cmd(input int id, input longint unsigned addr, input longint unsigned len,
                             input int burst, input int size, input int off);
        longint unsigned step, a, r, n, cap, bnd;
        burst_t b;
        step = longint'(1) << size;
        a = addr - (addr % step);
        r = len - (len % step);
        while (r > 0) begin
            n   = r / step;
            cap = (burst == 0) ? 16 : MAXB;
            if (n > cap) n = cap;
`ifdef DMAC_WR_4K_BOUNDARY_EN
            if (burst != 0) begin
                bnd = (4096 - (a % 4096)) / step;
                if (n > bnd) n = bnd;
            end
`else
            bnd = 0;
`endif
            b.addr = a; b.len = int'(n) - 1; b.last = (r == n * step) ? 1 : 0;
            b.id = id; b.burst = burst; b.size = size; b.off = off;
            exp_q.push_back(b);
            r = r - n * step;
            if (burst != 0) a = a + n * step;
        end
        done_q.push_back(id);
    endtask

    function automatic logic [1:0] rand_resp();
        int r;
        r = $urandom_range(0, 9);
        if (rand_err_en == 0) return 2'b00;
        if (r == 0) return 2'b10;
        if (r == 1) return 2'b11;
        if (r == 2) return 2'b01;
        return 2'b00;
    endfunction

    // Sink-side drivers: request ready, done ready, responses
    initial begin
        forever begin
            @(posedge clk);
            #1;
            wr_req_ready = (ready_mode == 2) ? ($urandom_range(0, 3) != 0) : (ready_mode == 1);
            done_ready   = (done_mode == 2) ? ($urandom_range(0, 2) != 0) : (done_mode == 1);
            if (resp_mode == 1)      wr_resp_valid = ($urandom_range(0, 2) == 0);
            else if (resp_mode == 2) wr_resp_valid = (manual_pending > 0);
            else                     wr_resp_valid = 1'b0;
            wr_resp_resp = (script_q.size() > 0) ? script_q[0] : rand_resp();
        end
    end

    // Monitor and scoreboard, sampling on the falling edge
    int          hold_v = 0;
    logic [AW-1:0] hold_addr;
    logic [7:0]  hold_len;
    logic        hold_last;
    initial begin
        burst_t e;
        int     d;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete(); done_q.delete(); script_q.delete();
                model_out = 0; err_acc = 0; hold_v = 0; manual_pending = 0;
            end else begin
                chk("resp_ready", wr_resp_ready, (model_out > 0) ? 1 : 0);
                if (wr_req_valid) begin
                    chk("req_under_limit", (model_out < MAXO) ? 1 : 0, 1);
                    chk("req_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                    if (hold_v != 0) begin
                        chk("stable_addr", wr_req_addr, hold_addr);
                        chk("stable_len", wr_req_len, hold_len);
                        chk("stable_last", wr_req_last, hold_last);
                    end
                end else if (hold_v != 0) begin
                    chk("stable_valid", wr_req_valid, 1);
                end
                hold_v = (wr_req_valid && !wr_req_ready) ? 1 : 0;
                hold_addr = wr_req_addr; hold_len = wr_req_len; hold_last = wr_req_last;

                if (wr_req_valid && wr_req_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("burst_addr", wr_req_addr, e.addr);
                    chk("burst_len", wr_req_len, e.len);
                    chk("burst_last", wr_req_last, e.last);
                    chk("burst_id", wr_req_id, e.id);
                    chk("burst_type", wr_req_burst, e.burst);
                    chk("burst_size", wr_req_size, e.size);
                    chk("burst_offset", wr_req_data_offset, e.off);
                    $display("burst id=%0d addr=0x%08h len=%0d last=%0d", wr_req_id, wr_req_addr, wr_req_len, wr_req_last);
                    model_out++;
                    fires++;
                end
                if (wr_resp_valid && wr_resp_ready) begin
                    model_out--;
                    if (wr_resp_resp[1]) err_acc = 1;
                    if (script_q.size() > 0) void'(script_q.pop_front());
                    if (manual_pending > 0) manual_pending--;
                end
                if (done_valid) begin
                    chk("done_expected", (done_q.size() > 0) ? 1 : 0, 1);
                    if (done_ready && done_q.size() > 0) begin
                        d = done_q.pop_front();
                        chk("done_id", done_id, d);
                        chk("done_err", done_err, err_acc);
                        $display("done id=%0d err=%0d", done_id, done_err);
                        last_done_id = int'(done_id);
                        last_done_err = int'(done_err);
                        err_acc = 0;
                    end
                end
                if (cmd_in_valid && cmd_in_ready) begin
                    $display("cmd id=%0d addr=0x%08h len=%0d burst=%0d size=%0d", cmd_in_id, cmd_in_dst_addr, cmd_in_len, cmd_in_burst, cmd_in_size);
                    model_cmd(int'(cmd_in_id), cmd_in_dst_addr, cmd_in_len, int'(cmd_in_burst), int'(cmd_in_size), int'(cmd_in_src_offset));
                end
            end
        end
    end

    task automatic send_cmd(input int id, input longint unsigned addr, input longint unsigned len,
                            input int burst, input int size, input int off);
        int ok;
        @(posedge clk);
        #1;
        cmd_in_valid = 1'b1;
        cmd_in_id = IDW'(id); cmd_in_dst_addr = AW'(addr); cmd_in_len = AW'(len);
        cmd_in_burst = 2'(burst); cmd_in_size = 3'(size); cmd_in_src_offset = OW'(off);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cmd_in_ready) begin ok = 1; break; end
        end
        chk("cmd_accept", ok, 1);
        @(posedge clk);
        #1;
        cmd_in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && done_q.size() == 0 && model_out == 0 && !done_valid) begin
                ok = 1; break;
            end
        end
        chk("drain_complete", ok, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, f0, acc;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_in_ready, 1);
        chk("rst_req_valid", wr_req_valid, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_resp_ready", wr_resp_ready, 0);

        // Two 16-beat INCR bursts, first request three cycles after accept
        send_cmd(1, 32'h1000, 128, 1, 2, 1);
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (wr_req_valid) begin k = i; break; end
        end
        chk("first_req_latency", k, 3);
        wait_idle(500);

        // 4 KB boundary case
        send_cmd(2, 32'h0FF8, 32, 1, 2, 0);
        wait_idle(500);

        // SLVERR on second response, then a clean command
        script_q.push_back(2'b00); script_q.push_back(2'b10);
        send_cmd(3, 32'h3000, 128, 1, 2, 0);
        wait_idle(500);
        chk("slverr_done_err", last_done_err, 1);
        chk("slverr_done_id", last_done_id, 3);
        script_q.push_back(2'b00); script_q.push_back(2'b00);
        send_cmd(4, 32'h3100, 128, 1, 2, 0);
        wait_idle(500);
        chk("clean_done_err", last_done_err, 0);

        // Outstanding limit with responses withheld
        resp_mode = 2;
        f0 = fires;
        send_cmd(5, 32'h2000, 256, 1, 2, 0);
        repeat (12) @(posedge clk);
        @(negedge clk); #1;
        chk("maxout_fires", fires - f0, 2);
        chk("maxout_valid_low", wr_req_valid, 0);
        manual_pending = 1;
        repeat (6) @(posedge clk);
        @(negedge clk); #1;
        chk("maxout_resume_fires", fires - f0, 3);
        chk("maxout_valid_low2", wr_req_valid, 0);
        resp_mode = 1;
        wait_idle(500);

        // Zero-length command
        send_cmd(6, 32'h4000, 0, 1, 2, 0);
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done_valid) begin k = i; break; end
        end
        chk("len0_done_within_4", (k >= 1 && k <= 4) ? 1 : 0, 1);
        wait_idle(500);

        // FIFO fills with the active command stalled
        ready_mode = 0;
        @(posedge clk); #1;
        acc = 0;
        cmd_in_valid = 1'b1; cmd_in_id = 3'd0; cmd_in_dst_addr = 32'h5000;
        cmd_in_len = 64; cmd_in_burst = 2'b01; cmd_in_size = 3'd2; cmd_in_src_offset = '0;
        for (int i = 0; i < 40 && acc < DEP + 1; i++) begin
            @(negedge clk);
            if (cmd_in_ready) acc++;
            @(posedge clk); #1;
            cmd_in_id = IDW'(acc);
            cmd_in_dst_addr = AW'(32'h5000 + acc * 32'h100);
            if (acc >= DEP + 1) cmd_in_valid = 1'b0;
        end
        chk("fifo_accepts", acc, DEP + 1);
        @(negedge clk);
        chk("fifo_full_ready", cmd_in_ready, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("fifo_full_ready_hold", cmd_in_ready, 0);
        ready_mode = 1;
        wait_idle(2000);

        // Reset during ISSUE
        ready_mode = 0;
        send_cmd(7, 32'h6000, 64, 1, 2, 3);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_req_valid) begin k = 1; break; end
        end
        chk("rst_issue_reached", k, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_req_valid", wr_req_valid, 0);
        chk("midrst_req_addr", wr_req_addr, 0);
        chk("midrst_req_len", wr_req_len, 0);
        chk("midrst_req_offset", wr_req_data_offset, 0);
        chk("midrst_req_last", wr_req_last, 0);
        chk("midrst_done_valid", done_valid, 0);
        chk("midrst_resp_ready", wr_resp_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        ready_mode = 1;
        @(negedge clk);
        chk("postrst_cmd_ready", cmd_in_ready, 1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("postrst_no_done", done_valid, 0);

        // Randomized traffic
        ready_mode = 2; done_mode = 2; rand_err_en = 1;
        for (int n = 0; n < 40; n++) begin
            int burst, size, len;
            burst = ($urandom_range(0, 3) == 0) ? 0 : 1;
            size  = $urandom_range(0, 2);
            len   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 600);
            send_cmd($urandom_range(0, 7), longint'($urandom_range(0, 32'h1FFFF)), len,
                     burst, size, $urandom_range(0, 3));
        end
        wait_idle(40000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
